subway_move_checker: RTL and testbench

Receiver-side replay checker for the subway runner interface. It loads the same 4-lane × 64-column map that is driven into the path-finding block, then consumes that block's move stream (`out_valid`/`out`). It replays the runner lane by lane, checks every move against the map rules, and reports pass/fail with the first offending step. It sits in the bench and on-chip self-test path, directly on the path-finder's output port.

---
 rtl/subway_pkg.sv | 34 +++
 rtl/subway_move_rule.sv | 40 ++++
 rtl/subway_move_checker.sv | 204 ++++++++++++++++++++
 tb/tb_subway_move_checker.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subway_pkg.sv
// Shared encodings and types for the subway runner move checker.
package subway_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned CELL_W = 2;
    localparam int unsigned STEP_W = 6;

    localparam logic [1:0] MV_FWD   = 2'd0;
    localparam logic [1:0] MV_RIGHT = 2'd1;
    localparam logic [1:0] MV_LEFT  = 2'd2;
    localparam logic [1:0] MV_JUMP  = 2'd3;

    localparam logic [1:0] CELL_ROAD  = 2'd0;
    localparam logic [1:0] CELL_LOW   = 2'd1;
    localparam logic [1:0] CELL_HIGH  = 2'd2;
    localparam logic [1:0] CELL_TRAIN = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_SHORT   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // One map column, index = lane.
    typedef logic [LANES-1:0][CELL_W-1:0] column_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_RUN,
        ST_REPORT
    } state_t;

endpackage

// File: rtl/subway_move_rule.sv
// Combinational legality check and lane update for one runner move.
module subway_move_rule
    import subway_pkg::*;
(
    input  logic [1:0] lane,
    input  logic [1:0] mv,
    input  column_t    col,
    output logic       legal,
    output logic [1:0] next_lane
);

    logic [1:0] lane_up;
    logic [1:0] lane_dn;

    assign lane_up = lane + 2'd1;
    assign lane_dn = lane - 2'd1;

    // Sidesteps move the lane even when blocked; only the map edges hold it.
    always_comb begin
        legal     = 1'b0;
        next_lane = lane;
        case (mv)
            MV_FWD: legal = (col[lane] == CELL_ROAD) || (col[lane] == CELL_HIGH);
            MV_RIGHT: begin
                if (lane != 2'd3) begin
                    next_lane = lane_up;
                    legal     = (col[lane_up] == CELL_ROAD);
                end
            end
            MV_LEFT: begin
                if (lane != 2'd0) begin
                    next_lane = lane_dn;
                    legal     = (col[lane_dn] == CELL_ROAD);
                end
            end
            default: legal = (col[lane] == CELL_ROAD) || (col[lane] == CELL_LOW);
        endcase
    end

endmodule

// File: rtl/subway_move_checker.sv
// Replays the path-finder move stream against the loaded map and reports a verdict.
module subway_move_checker
    import subway_pkg::*;
#(
    parameter int unsigned COLS    = 64,
    parameter int unsigned TIMEOUT = 3000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [1:0] init,
    input  logic [1:0] in0,
    input  logic [1:0] in1,
    input  logic [1:0] in2,
    input  logic [1:0] in3,
    input  logic       mv_valid,
    input  logic [1:0] mv,
    output logic       done,
    output logic       pass,
    output logic [1:0] err_code,
    output logic [5:0] err_step,
    output logic [1:0] final_lane
);

    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(COLS - 2);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);

    state_t             state_q, state_d;
    logic [COL_W-1:0]   ld_cnt_q, ld_cnt_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [1:0]         lane_q, lane_d;
    logic               bad_q, bad_d;
    logic [STEP_W-1:0]  bad_step_q, bad_step_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [STEP_W-1:0]  err_step_q, err_step_d;
    logic [1:0]         final_lane_q, final_lane_d;

    column_t            map_q [COLS];
    column_t            wr_col;
    logic               wr_en;
    logic [COL_W-1:0]   wr_idx;
    logic [COL_W-1:0]   nxt_idx;

    logic               mv_legal;
    logic [1:0]         mv_lane;

    logic               fin;
    logic [1:0]         fin_code;
    logic [STEP_W-1:0]  fin_step;
    logic [1:0]         fin_lane;

    assign wr_col  = {in3, in2, in1, in0};
    assign nxt_idx = COL_W'(step_q) + COL_W'(1);

    subway_move_rule u_rule (
        .lane      (lane_q),
        .mv        (mv),
        .col       (map_q[nxt_idx]),
        .legal     (mv_legal),
        .next_lane (mv_lane)
    );

    // Next-state, counters and verdict.
    always_comb begin
        state_d      = state_q;
        ld_cnt_d     = ld_cnt_q;
        step_d       = step_q;
        tmo_d        = tmo_q;
        lane_d       = lane_q;
        bad_d        = bad_q;
        bad_step_d   = bad_step_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_code_d   = err_code_q;
        err_step_d   = err_step_q;
        final_lane_d = final_lane_q;
        wr_en        = 1'b0;
        wr_idx       = ld_cnt_q;
        fin          = 1'b0;
        fin_code     = ERR_NONE;
        fin_step     = '0;
        fin_lane     = lane_q;

        if (in_valid && (state_q != ST_LOAD)) begin
            // A new map always restarts the check from column 0.
            wr_en      = 1'b1;
            wr_idx     = '0;
            ld_cnt_d   = COL_W'(1);
            lane_d     = init;
            step_d     = '0;
            tmo_d      = '0;
            bad_d      = 1'b0;
            bad_step_d = '0;
            state_d    = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (in_valid) begin
                        wr_en = 1'b1;
                        if (ld_cnt_q == LAST_COL) begin
                            state_d = ST_WAIT;
                        end else begin
                            ld_cnt_d = ld_cnt_q + COL_W'(1);
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT, ST_RUN: begin
                    if (mv_valid) begin
                        state_d = ST_RUN;
                        lane_d  = mv_lane;
                        step_d  = (step_q == '1) ? step_q : step_q + STEP_W'(1);
                        if (!mv_legal && !bad_q) begin
                            bad_d      = 1'b1;
                            bad_step_d = step_q;
                        end
                        if (step_q == LAST_STEP) begin
                            fin      = 1'b1;
                            fin_lane = mv_lane;
                            if (bad_q) begin
                                fin_code = ERR_ILLEGAL;
                                fin_step = bad_step_q;
                            end else if (!mv_legal) begin
                                fin_code = ERR_ILLEGAL;
                                fin_step = step_q;
                            end
                        end
                    end else if (state_q == ST_RUN) begin
                        fin      = 1'b1;
                        fin_code = ERR_SHORT;
                        fin_step = step_q;
                    end else if (tmo_q == TMO_LAST) begin
                        fin      = 1'b1;
                        fin_code = ERR_TIMEOUT;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                ST_REPORT: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end

        if (fin) begin
            state_d      = ST_REPORT;
            done_d       = 1'b1;
            pass_d       = (fin_code == ERR_NONE);
            err_code_d   = fin_code;
            err_step_d   = fin_step;
            final_lane_d = fin_lane;
        end
    end

    // State, map and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ld_cnt_q     <= '0;
            step_q       <= '0;
            tmo_q        <= '0;
            lane_q       <= '0;
            bad_q        <= 1'b0;
            bad_step_q   <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_code_q   <= '0;
            err_step_q   <= '0;
            final_lane_q <= '0;
            for (int i = 0; i < COLS; i++) begin
                map_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ld_cnt_q     <= ld_cnt_d;
            step_q       <= step_d;
            tmo_q        <= tmo_d;
            lane_q       <= lane_d;
            bad_q        <= bad_d;
            bad_step_q   <= bad_step_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_code_q   <= err_code_d;
            err_step_q   <= err_step_d;
            final_lane_q <= final_lane_d;
            if (wr_en) begin
                map_q[wr_idx] <= wr_col;
            end
        end
    end

    assign done       = done_q;
    assign pass       = pass_q;
    assign err_code   = err_code_q;
    assign err_step   = err_step_q;
    assign final_lane = final_lane_q;

endmodule

// File: tb/tb_subway_move_checker.sv
// Randomized replay bench for subway_move_checker with a path-level reference model.
module tb_subway_move_checker;

    localparam int TB_COLS = 64;
    localparam int TB_TMO  = 20;
    localparam int MOVES   = TB_COLS - 1;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] init;
    logic [1:0] in0, in1, in2, in3;
    logic       mv_valid;
    logic [1:0] mv;
    logic       done;
    logic       pass;
    logic [1:0] err_code;
    logic [5:0] err_step;
    logic [1:0] final_lane;

    subway_move_checker #(.COLS(TB_COLS), .TIMEOUT(TB_TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .init       (init),
        .in0        (in0),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .mv_valid   (mv_valid),
        .mv         (mv),
        .done       (done),
        .pass       (pass),
        .err_code   (err_code),
        .err_step   (err_step),
        .final_lane (final_lane)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Test vectors: map[lane][col], start lane, move list.
    logic [1:0] tmap [4][TB_COLS];
    logic [1:0] tmoves [MOVES];
    logic [1:0] tinit;

    typedef struct {
        int cyc;
        int pass;
        int code;
        int step;
        int lane;
    } exp_t;
    exp_t expq[$];

    int done_cnt = 0;
    int last_pass, last_code, last_step, last_lane;

    // Runner rules applied to the map directly.
    function automatic int next_lane(input int lane, input logic [1:0] m, input int col, output bit ok);
        int nl;
        nl = lane;
        ok = 1'b0;
        case (m)
            2'd0: ok = (tmap[lane][col] == 2'd0) || (tmap[lane][col] == 2'd2);
            2'd1: if (lane < 3) begin nl = lane + 1; ok = (tmap[nl][col] == 2'd0); end
            2'd2: if (lane > 0) begin nl = lane - 1; ok = (tmap[nl][col] == 2'd0); end
            default: ok = (tmap[lane][col] == 2'd0) || (tmap[lane][col] == 2'd1);
        endcase
        return nl;
    endfunction

    function automatic void model(input int n, output exp_t e);
        int  l;
        int  first;
        bit  ok;
        l = int'(tinit);
        first = -1;
        for (int k = 0; k < n; k++) begin
            l = next_lane(l, tmoves[k], k + 1, ok);
            if (!ok && first < 0) first = k;
        end
        e.lane = l;
        if (n < MOVES)      begin e.code = 2; e.step = n;     end
        else if (first >= 0) begin e.code = 1; e.step = first; end
        else                begin e.code = 0; e.step = 0;     end
        e.pass = (e.code == 0) ? 1 : 0;
    endfunction

    // Single compare process: done must pulse exactly on predicted cycles.
    always @(negedge clk) begin
        if (rst_n) begin
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                exp_t e;
                e = expq.pop_front();
                check("done", int'(done), 1);
                check("pass", int'(pass), e.pass);
                check("err_code", int'(err_code), e.code);
                check("err_step", int'(err_step), e.step);
                check("final_lane", int'(final_lane), e.lane);
                done_cnt++;
                last_pass = int'(pass);
                last_code = int'(err_code);
                last_step = int'(err_step);
                last_lane = int'(final_lane);
            end else begin
                check("no_done", int'(done), 0);
            end
        end
    end

    task automatic clear_vec(input logic [1:0] start);
        tinit = start;
        for (int l = 0; l < 4; l++)
            for (int c = 0; c < TB_COLS; c++) tmap[l][c] = 2'd0;
        for (int k = 0; k < MOVES; k++) tmoves[k] = 2'd0;
    endtask

    task automatic rand_vec(input bit seek_legal);
        int  l;
        bit  ok;
        logic [1:0] m;
        tinit = 2'($urandom);
        for (int ln = 0; ln < 4; ln++)
            for (int c = 0; c < TB_COLS; c++)
                tmap[ln][c] = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
        l = int'(tinit);
        for (int k = 0; k < MOVES; k++) begin
            m = 2'($urandom);
            if (seek_legal) begin
                for (int t = 0; t < 8; t++) begin
                    void'(next_lane(l, m, k + 1, ok));
                    if (ok) break;
                    m = 2'($urandom);
                end
            end
            tmoves[k] = m;
            l = next_lane(l, m, k + 1, ok);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            mv_valid = 1'b0;
        end
    endtask

    // Load the map, then stream nbeats moves; abort leaves the run unfinished.
    task automatic run_case(input int load_len, input int wait_cyc, input int nbeats, input bit abort);
        int   l_cyc;
        exp_t e;
        for (int c = 0; c < load_len; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            init     = (c == 0) ? tinit : 2'($urandom);
            in0 = tmap[0][c]; in1 = tmap[1][c]; in2 = tmap[2][c]; in3 = tmap[3][c];
            mv_valid = 1'($urandom);
            mv       = 2'($urandom);
        end
        l_cyc = cyc;
        if (load_len < TB_COLS) begin
            idle(3);
            return;
        end
        if (!abort && wait_cyc >= TB_TMO) begin
            e.cyc = l_cyc + TB_TMO + 1; e.pass = 0; e.code = 3; e.step = 0; e.lane = int'(tinit);
            expq.push_back(e);
            idle(TB_TMO + 3);
            return;
        end
        if (!abort) begin
            model(nbeats, e);
            e.cyc = (nbeats == MOVES) ? l_cyc + 1 + wait_cyc + MOVES
                                      : l_cyc + 1 + wait_cyc + nbeats + 1;
            expq.push_back(e);
        end
        idle(wait_cyc);
        for (int k = 0; k < nbeats; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            mv_valid = 1'b1;
            mv       = tmoves[k];
        end
        if (abort) return;
        if (nbeats == MOVES) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                mv_valid = 1'b1;
                mv       = 2'($urandom);
            end
        end
        idle(3);
    endtask

    int d0;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; init = '0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        mv_valid = 1'b0; mv = '0;
        repeat (3) @(negedge clk);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_code", int'(err_code), 0);
        check("rst_step", int'(err_step), 0);
        check("rst_lane", int'(final_lane), 0);
        rst_n = 1'b1;
        idle(2);

        // All road, straight ahead from lane 1.
        clear_vec(2'd1);
        run_case(TB_COLS, 0, MOVES, 1'b0);
        check("t1_pass", last_pass, 1);
        check("t1_code", last_code, 0);
        check("t1_lane", last_lane, 1);

        // Train ahead at step 5 and a blocked left from lane 0.
        clear_vec(2'd0);
        tmap[0][6] = 2'd3;
        tmoves[5]  = 2'd2;
        run_case(TB_COLS, 3, MOVES, 1'b0);
        check("t2_code", last_code, 1);
        check("t2_step", last_step, 5);
        check("t2_lane", last_lane, 0);

        // Jump a low bar, sidestep right, run under a high bar.
        clear_vec(2'd2);
        tmap[2][10] = 2'd1;
        tmap[3][20] = 2'd2;
        tmoves[9]   = 2'd3;
        tmoves[18]  = 2'd1;
        run_case(TB_COLS, TB_TMO - 1, MOVES, 1'b0);
        check("t3_pass", last_pass, 1);
        check("t3_lane", last_lane, 3);

        // Stream stops after 10 beats.
        clear_vec(2'd3);
        run_case(TB_COLS, 1, 10, 1'b0);
        check("t4_code", last_code, 2);
        check("t4_step", last_step, 10);

        // No moves at all.
        clear_vec(2'd2);
        run_case(TB_COLS, TB_TMO, 0, 1'b0);
        check("t5_code", last_code, 3);
        check("t5_lane", last_lane, 2);

        // Reset in the middle of a run.
        clear_vec(2'd0);
        run_case(TB_COLS, 2, 20, 1'b1);
        @(negedge clk);
        rst_n = 1'b0; mv_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_code", int'(err_code), 0);
        check("mid_rst_step", int'(err_step), 0);
        check("mid_rst_pass", int'(pass), 0);
        rst_n = 1'b1;
        idle(2);
        clear_vec(2'd1);
        run_case(TB_COLS, 0, MOVES, 1'b0);
        check("t6_pass", last_pass, 1);

        // New map mid-run discards the old check; a partial load goes quiet.
        d0 = done_cnt;
        rand_vec(1'b1);
        run_case(TB_COLS, 0, 30, 1'b1);
        rand_vec(1'b0);
        run_case(37, 0, 0, 1'b0);
        clear_vec(2'd2);
        run_case(TB_COLS, 5, MOVES, 1'b0);
        check("abort_done_cnt", done_cnt, d0 + 1);
        check("t7_lane", last_lane, 2);

        for (int r = 0; r < 30; r++) begin
            int mode;
            mode = $urandom_range(0, 9);
            rand_vec(1'($urandom));
            case (mode)
                0: run_case(TB_COLS, TB_TMO + $urandom_range(0, 3), 0, 1'b0);
                1: run_case(TB_COLS, $urandom_range(0, TB_TMO - 1), $urandom_range(1, MOVES - 1), 1'b0);
                2: run_case(TB_COLS, $urandom_range(0, 5), $urandom_range(0, MOVES - 1), 1'b1);
                3: run_case($urandom_range(1, TB_COLS - 1), 0, 0, 1'b0);
                default: run_case(TB_COLS, $urandom_range(0, TB_TMO - 1), MOVES, 1'b0);
            endcase
        end

        idle(TB_TMO + 5);
        check("pending_verdicts", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
